plru_repl_engine: RTL and testbench

- Sequential, parametrised tree-PLRU replacement engine for the LLC: owns the PLRU state for every set; no longer a per-call function on caller-held bits.
- Accepts touch, victim-query, victim-and-fill and clear requests over a valid/ready handshake. Returns victims over a separate valid/ready response channel.
- Adds three capabilities: per-request way-lock mask, invalid-way preference, and a self-clearing reset sweep.
- Sits beside the tag array in the LLC controller.

---
 rtl/plru_repl_engine_pkg.sv | 16 +
 rtl/plru_repl_engine_tree.sv | 71 +++++++
 rtl/plru_repl_engine.sv | 125 ++++++++++++
 tb/tb_plru_repl_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/plru_repl_engine_pkg.sv
// Shared types and default geometry for the LLC tree-PLRU replacement engine.
package plru_repl_engine_pkg;
    localparam int N_WAY = 16;
    localparam int N_SET = 16384;

    typedef enum logic [1:0] {
        OP_TOUCH  = 2'd0,
        OP_VICTIM = 2'd1,
        OP_FILL   = 2'd2,
        OP_CLEAR  = 2'd3
    } repl_op_e;

    typedef enum logic {ST_INIT, ST_RUN} eng_state_e;

    typedef logic [N_WAY-1:0] way_mask_t;
endpackage

// File: rtl/plru_repl_engine_tree.sv
// Combinational tree-PLRU core: victim choice with invalid/lock masks, plus
// the touch update for both the requested way and the chosen victim.
module plru_tree_logic #(
    parameter int N_WAY = 16,
    parameter int WAY_W = $clog2(N_WAY)
) (
    input  logic [N_WAY-2:0] bits,
    input  logic [WAY_W-1:0] way,
    input  logic [N_WAY-1:0] inv_mask,
    input  logic [N_WAY-1:0] lock_mask,
    output logic [WAY_W-1:0] victim,
    output logic             invalid,
    output logic             none,
    output logic [N_WAY-2:0] touch_bits,
    output logic [N_WAY-2:0] fill_bits
);
    import plru_repl_engine_pkg::*;

    // Each node on the path records the direction of the most recent touch.
    function automatic logic [N_WAY-2:0] apply_touch(input logic [N_WAY-2:0] b,
                                                     input logic [WAY_W-1:0] w);
        logic [N_WAY-2:0] r;
        int node;
        r    = b;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[node] = w[WAY_W-1-l];
            node    = 2*node + 1 + int'(w[WAY_W-1-l]);
        end
        return r;
    endfunction

    always_comb begin
        logic [N_WAY-1:0] elig;
        logic             inv_hit;
        logic [WAY_W-1:0] inv_way;
        logic             d;
        logic             any_d;
        int               node;
        int               p;
        elig    = ~lock_mask;
        inv_hit = 1'b0;
        inv_way = '0;
        for (int i = N_WAY-1; i >= 0; i--) begin
            if (inv_mask[i] && elig[i]) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(i);
            end
        end
        node = 0;
        p    = 0;
        // Steer away from the last touch unless that whole subtree is locked.
        for (int l = 0; l < WAY_W; l++) begin
            d     = ~bits[node];
            any_d = 1'b0;
            for (int i = 0; i < N_WAY; i++) begin
                if (elig[i] && ((i >> (WAY_W-1-l)) == ((p << 1) | int'(d))))
                    any_d = 1'b1;
            end
            if (!any_d) d = ~d;
            p    = (p << 1) | int'(d);
            node = 2*node + 1 + int'(d);
        end
        none    = ~|elig;
        invalid = !none && inv_hit;
        victim  = none ? '0 : (inv_hit ? inv_way : WAY_W'(p));
    end

    assign touch_bits = apply_touch(bits, way);
    assign fill_bits  = apply_touch(bits, victim);
endmodule

// File: rtl/plru_repl_engine.sv
// LLC tree-PLRU engine: per-set state array, zeroing sweep after reset, and a
// two-stage read/modify/write pipeline with same-set bypass and response backpressure.
module plru_repl_engine #(
    parameter int N_WAY = plru_repl_engine_pkg::N_WAY,
    parameter int N_SET = plru_repl_engine_pkg::N_SET,
    parameter int WAY_W = $clog2(N_WAY),
    parameter int SET_W = $clog2(N_SET)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic [N_WAY-1:0] req_inv_mask,
    input  logic [N_WAY-1:0] req_lock_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_invalid,
    output logic             rsp_none
);
    import plru_repl_engine_pkg::*;

    typedef struct packed {
        repl_op_e         op;
        logic [SET_W-1:0] idx;
        logic [WAY_W-1:0] way;
        logic [N_WAY-1:0] inv;
        logic [N_WAY-1:0] lock;
    } req_t;

    eng_state_e       state_q, state_d;
    logic [SET_W-1:0] init_cnt;
    logic [N_WAY-2:0] mem [N_SET];

    req_t             s1, s2;
    logic             s1_vld, s2_vld;
    logic [N_WAY-2:0] s2_bits, s2_new;
    logic             s2_wr, adv, accept;
    logic             wr_en;
    logic [SET_W-1:0] wr_set;
    logic [N_WAY-2:0] wr_bits;

    logic [WAY_W-1:0] t_victim;
    logic             t_invalid, t_none;
    logic [N_WAY-2:0] t_touch, t_fill;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt == SET_W'(N_SET-1)) state_d = ST_RUN;
    end

    assign init_done = (state_q == ST_RUN);
    assign adv       = !(rsp_valid && !rsp_ready);
    assign req_ready = init_done && !rst && adv;
    assign accept    = req_valid && req_ready;

    plru_tree_logic #(.N_WAY(N_WAY), .WAY_W(WAY_W)) u_tree (
        .bits      (s2_bits),
        .way       (s2.way),
        .inv_mask  (s2.inv),
        .lock_mask (s2.lock),
        .victim    (t_victim),
        .invalid   (t_invalid),
        .none      (t_none),
        .touch_bits(t_touch),
        .fill_bits (t_fill)
    );

    always_comb begin
        s2_new = t_fill;
        if (s2.op == OP_CLEAR)      s2_new = '0;
        else if (s2.op == OP_TOUCH) s2_new = t_touch;
    end

    // A plain VICTIM never writes; a fill with no eligible way leaves the set untouched.
    assign s2_wr = s2_vld && adv &&
                   (s2.op == OP_TOUCH || s2.op == OP_CLEAR || (s2.op == OP_FILL && !t_none));

    assign wr_en   = !rst && ((state_q == ST_INIT) || s2_wr);
    assign wr_set  = (state_q == ST_INIT) ? init_cnt : s2.idx;
    assign wr_bits = (state_q == ST_INIT) ? '0 : s2_new;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_set] <= wr_bits;
        if (adv) begin
            s1      <= '{op: repl_op_e'(req_op), idx: req_set, way: req_way,
                         inv: req_inv_mask, lock: req_lock_mask};
            s2      <= s1;
            s2_bits <= (s2_wr && s2.idx == s1.idx) ? s2_new : mem[s1.idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt    <= '0;
            s1_vld      <= 1'b0;
            s2_vld      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_way     <= '0;
            rsp_invalid <= 1'b0;
            rsp_none    <= 1'b0;
        end else begin
            if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (adv) begin
                s1_vld    <= accept;
                s2_vld    <= s1_vld;
                rsp_valid <= s2_vld && (s2.op == OP_VICTIM || s2.op == OP_FILL);
                if (s2_vld && (s2.op == OP_VICTIM || s2.op == OP_FILL)) begin
                    rsp_way     <= t_victim;
                    rsp_invalid <= t_invalid;
                    rsp_none    <= t_none;
                end
            end
        end
    end
endmodule

// File: tb/tb_plru_repl_engine.sv
// Bench for plru_repl_engine: vector table through a response scoreboard, plus
// sequences for init timing, latency, backpressure and mid-flight reset.
module tb_plru_repl_engine;
    import plru_repl_engine_pkg::*;

    localparam int WAY_W = $clog2(N_WAY);
    localparam int SET_W = $clog2(N_SET);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_done, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]       req_op;
    logic [SET_W-1:0] req_set;
    logic [WAY_W-1:0] req_way, rsp_way;
    way_mask_t        req_inv_mask, req_lock_mask;
    logic             rsp_invalid, rsp_none;

    plru_repl_engine dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_set(req_set), .req_way(req_way),
        .req_inv_mask(req_inv_mask), .req_lock_mask(req_lock_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_way(rsp_way),
        .rsp_invalid(rsp_invalid), .rsp_none(rsp_none)
    );

    always #5 clk = ~clk;

    typedef struct {
        int way;
        bit inv;
        bit none;
    } exp_t;

    typedef struct {
        repl_op_e  op;
        int        set;
        int        way;
        way_mask_t inv;
        way_mask_t lock;
        bit        has;
        int        e_way;
        bit        e_inv;
        bit        e_none;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_way", int'(rsp_way), e.way);
                check("rsp_invalid", int'(rsp_invalid), int'(e.inv));
                check("rsp_none", int'(rsp_none), int'(e.none));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input repl_op_e op, input int set, input int way,
                        input way_mask_t inv, input way_mask_t lock,
                        input bit has, input int ew, input bit ei, input bit en);
        int budget;
        budget        = 0;
        req_op        = op;
        req_set       = SET_W'(set);
        req_way       = WAY_W'(way);
        req_inv_mask  = inv;
        req_lock_mask = lock;
        req_valid     = 1'b1;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (has) sb.push_back('{ew, ei, en});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    function automatic vec_t v(input repl_op_e op, input int set, input int way,
                               input way_mask_t inv, input way_mask_t lock,
                               input bit has, input int ew, input bit ei, input bit en);
        vec_t r;
        r = '{op, set, way, inv, lock, has, ew, ei, en};
        return r;
    endfunction

    task automatic wait_init(input string name);
        int cyc;
        bit ready_early;
        cyc         = 0;
        ready_early = 1'b0;
        while (!init_done && cyc < N_SET + 100) begin
            if (req_ready) ready_early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({name, "_cycles"}, cyc, N_SET);
        check({name, "_ready_low"}, int'(ready_early), 0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        req_valid = 1'b0; req_op = '0; req_set = '0; req_way = '0;
        req_inv_mask = '0; req_lock_mask = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_init_done", int'(init_done), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_way", int'(rsp_way), 0);
        check("rst_rsp_flags", int'({rsp_invalid, rsp_none}), 0);
        rst = 1'b0;
        wait_init("init");

        // Fresh set: all bits zero, so every node steers to the upper half.
        send(OP_VICTIM, 5, 0, '0, '0, 1, 15, 0, 0);
        wait_rsp(lat);
        check("victim_latency", lat, 2);
        drain();

        tbl.push_back(v(OP_TOUCH,  5,     15, 16'h0000, 16'h0000, 0, 0,  0, 0));
        tbl.push_back(v(OP_VICTIM, 5,     0,  16'h0000, 16'h0000, 1, 7,  0, 0));
        tbl.push_back(v(OP_VICTIM, 9,     0,  16'h0030, 16'h0010, 1, 5,  1, 0));
        tbl.push_back(v(OP_CLEAR,  3,     0,  16'h0000, 16'h0000, 0, 0,  0, 0));
        tbl.push_back(v(OP_VICTIM, 3,     0,  16'h0000, 16'hFF00, 1, 7,  0, 0));
        tbl.push_back(v(OP_VICTIM, 3,     0,  16'h0000, 16'hFFFF, 1, 0,  0, 1));
        tbl.push_back(v(OP_FILL,   2,     0,  16'h0000, 16'h0000, 1, 15, 0, 0));
        tbl.push_back(v(OP_FILL,   2,     0,  16'h0000, 16'h0000, 1, 7,  0, 0));
        tbl.push_back(v(OP_VICTIM, 2,     0,  16'h0000, 16'h0000, 1, 11, 0, 0));
        tbl.push_back(v(OP_TOUCH,  7,     3,  16'h0000, 16'h0000, 0, 0,  0, 0));
        tbl.push_back(v(OP_VICTIM, 7,     0,  16'h0000, 16'hFFF0, 1, 1,  0, 0));
        tbl.push_back(v(OP_VICTIM, 7,     0,  16'h0001, 16'h0001, 1, 15, 0, 0));
        tbl.push_back(v(OP_VICTIM, 7,     0,  16'h8001, 16'h0001, 1, 15, 1, 0));
        tbl.push_back(v(OP_FILL,   7,     0,  16'h0000, 16'hFFFF, 1, 0,  0, 1));
        tbl.push_back(v(OP_VICTIM, 7,     0,  16'h0000, 16'h0000, 1, 15, 0, 0));
        tbl.push_back(v(OP_TOUCH,  N_SET-1, 15, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(v(OP_VICTIM, N_SET-1, 0,  16'h0000, 16'h0000, 1, 7, 0, 0));
        tbl.push_back(v(OP_VICTIM, 12,    0,  16'h8000, 16'h0000, 1, 15, 1, 0));
        tbl.push_back(v(OP_VICTIM, 12,    0,  16'hFFFF, 16'h0003, 1, 2,  1, 0));
        for (int i = 0; i < tbl.size(); i++)
            send(tbl[i].op, tbl[i].set, tbl[i].way, tbl[i].inv, tbl[i].lock,
                 tbl[i].has, tbl[i].e_way, tbl[i].e_inv, tbl[i].e_none);
        drain();

        // Response stall: pipeline and response must freeze.
        rsp_ready = 1'b0;
        send(OP_CLEAR, 2, 0, '0, '0, 0, 0, 0, 0);
        send(OP_FILL,  2, 0, '0, '0, 1, 15, 0, 0);
        send(OP_FILL,  2, 0, '0, '0, 1, 7,  0, 0);
        wait_rsp(lat);
        for (int k = 0; k < 3; k++) begin
            check("stall_req_ready", int'(req_ready), 0);
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_way", int'(rsp_way), 15);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        drain();

        // Reset while a response is pending drops it and reruns the sweep.
        rsp_ready = 1'b0;
        send(OP_VICTIM, 5, 0, '0, '0, 0, 0, 0, 0);
        wait_rsp(lat);
        check("pre_rst_rsp_valid", int'(rsp_valid), 1);
        check("pre_rst_rsp_way", int'(rsp_way), 7);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_req_ready", int'(req_ready), 0);
        check("mid_rst_init_done", int'(init_done), 0);
        sb.delete();
        rst = 1'b0;
        wait_init("reinit");
        rsp_ready = 1'b1;
        send(OP_VICTIM, 5, 0, '0, '0, 1, 15, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
